// File: rtl/cpu16_pkg.sv
// Shared constants and types for the cpu16 front end.
// Holds the fetch FSM state enum and the prefetch queue entry layout.
package cpu16_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } ifu_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch queue with registered head; clear wins over push.
// Callers only pop when count is non-zero.
module fetch_fifo
  import cpu16_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  ifq_entry_t din,
  output logic [1:0] count,
  output ifq_entry_t head
);

  ifq_entry_t tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new entry lands behind whatever survives.
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding fetch FSM and prefetch queue.
// Optional fetch/flush statistics counters are built when IFU_FETCH_STATS_EN is defined.
module instr_fetch_unit #(
  parameter int PC_W    = cpu16_pkg::PC_W,
  parameter int INSTR_W = cpu16_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = cpu16_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               pc_jump,
  input  logic               pc_branch,
  input  logic [PC_W-1:0]    redirect_target
`ifdef IFU_FETCH_STATS_EN
  ,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  cpu16_pkg::ifu_state_t state, state_nxt;
  cpu16_pkg::ifq_entry_t head, din;
  logic [PC_W-1:0] pc;
  logic [1:0]      count;
  logic            redirect, pop, push, fetch_ok;

  assign redirect = pc_jump | pc_branch;
  assign pop      = instr_valid & instr_ready;
  assign push     = (state == cpu16_pkg::WAIT) & imem_rvalid & ~redirect;
  // A slot is reserved at issue time, so a response can never find the queue full.
  assign fetch_ok = (state == cpu16_pkg::FETCH) & ~redirect & ((count != 2'd2) | pop);

  assign imem_req    = rst_n & fetch_ok;
  assign imem_addr   = imem_req ? pc : '0;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign instr_valid = (count != 2'd0);
  assign din         = '{pc: pc, instr: imem_rdata};

  always_comb begin
    state_nxt = state;
    case (state)
      cpu16_pkg::FETCH:   if (fetch_ok) state_nxt = cpu16_pkg::WAIT;
      cpu16_pkg::WAIT: begin
        if (imem_rvalid)   state_nxt = cpu16_pkg::FETCH;
        else if (redirect) state_nxt = cpu16_pkg::DISCARD;
      end
      // The stale response still has to drain even if another redirect lands.
      cpu16_pkg::DISCARD: if (imem_rvalid) state_nxt = cpu16_pkg::FETCH;
      default:            state_nxt = cpu16_pkg::FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= cpu16_pkg::FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect)  pc <= redirect_target;
      else if (push) pc <= pc + 1'b1;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   (din),
    .count (count),
    .head  (head)
  );

`ifdef IFU_FETCH_STATS_EN
  logic flush_evt;
  // The entry accepted in the redirect cycle is consumed, not flushed.
  assign flush_evt = redirect & (((count - {1'b0, pop}) != 2'd0) | (state == cpu16_pkg::WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (push && fetch_cnt != 16'hFFFF)      fetch_cnt <= fetch_cnt + 16'd1;
      if (flush_evt && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic against a stream-level model.
// Stats checks are compiled in when IFU_FETCH_STATS_EN is defined.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        pc_jump = 1'b0;
  logic        pc_branch = 1'b0;
  logic [7:0]  redirect_target = '0;
`ifdef IFU_FETCH_STATS_EN
  logic [15:0] fetch_cnt, flush_cnt;
`endif

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .pc_jump         (pc_jump),
    .pc_branch       (pc_branch),
    .redirect_target (redirect_target)
`ifdef IFU_FETCH_STATS_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: stream expectations, memory model and queue occupancy.
  int         lat_cfg = 1;
  bit         pending, discard;
  int         lat_left;
  logic [7:0] pend_addr, exp_fetch, exp_dec;
  int         qcnt, cyc_n, pushes_m, flushes_m;
  logic [7:0]  req_addr_q[$];
  int          req_cyc_q[$];
  logic [15:0] acc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pending = 0; discard = 0; lat_left = 0;
    exp_fetch = 8'h00; exp_dec = 8'h00;
    qcnt = 0; cyc_n = 0; pushes_m = 0; flushes_m = 0;
    req_addr_q.delete(); req_cyc_q.delete(); acc_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    pc_jump = 1'b0; pc_branch = 1'b0;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_instr_valid", instr_valid, 0);
`ifdef IFU_FETCH_STATS_EN
    chk("rst_fetch_cnt", fetch_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One modelled clock cycle: drive memory, sample at mid-cycle, advance model, step past the edge.
  task automatic cyc();
    bit redir, acc, push, flush;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pending) begin
      if (lat_left <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = {8'h4D, pend_addr};
      end else begin
        lat_left--;
      end
    end
    #1;
    redir = pc_jump | pc_branch;
    acc   = instr_valid & instr_ready;
    chk("instr_valid", instr_valid, qcnt != 0);
    if (acc) begin
      chk("instr", instr, {8'h4D, exp_dec});
      chk("instr_pc", instr_pc, exp_dec);
      acc_q.push_back(instr);
      exp_dec = exp_dec + 8'd1;
    end
    if (redir) chk("req_in_redirect", imem_req, 0);
    if (imem_req) begin
      chk("one_outstanding", pending, 0);
      chk("imem_addr", imem_addr, exp_fetch);
      req_addr_q.push_back(imem_addr);
      req_cyc_q.push_back(cyc_n);
    end
    push  = imem_rvalid && !discard && !redir;
    flush = redir && ((pending && !discard) || (qcnt - int'(acc)) > 0);
    if (imem_rvalid) begin
      pending = 0; discard = 0;
    end else if (redir && pending) begin
      discard = 1;
    end
    if (imem_req) begin
      pending = 1; lat_left = lat_cfg; pend_addr = imem_addr;
      exp_fetch = exp_fetch + 8'd1;
    end
    if (redir) begin
      qcnt = 0; exp_fetch = redirect_target; exp_dec = redirect_target;
    end else begin
      qcnt = qcnt + int'(push) - int'(acc);
    end
    if (push)  pushes_m++;
    if (flush) flushes_m++;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, a0;
    bit found;
    model_clear();

    // Streaming from reset with a 1-cycle memory.
    do_reset();
    instr_ready = 1'b1; lat_cfg = 1;
    repeat (8) cyc();
    chk("first_req_cycle", req_cyc_q[0], 0);
    chk("seq_addr0", req_addr_q[0], 8'h00);
    chk("seq_addr1", req_addr_q[1], 8'h01);
    chk("seq_addr2", req_addr_q[2], 8'h02);
    chk("fetch_period1", req_cyc_q[1] - req_cyc_q[0], 2);
    chk("fetch_period2", req_cyc_q[2] - req_cyc_q[1], 2);
    chk("dec_first", acc_q[0], 16'h4D00);
    chk("dec_second", acc_q[1], 16'h4D01);

    // Back-pressure fills the queue, then one pop frees a slot.
    do_reset();
    instr_ready = 1'b0;
    repeat (12) cyc();
    chk("full_nreq", req_addr_q.size(), 2);
    chk("full_addr1", req_addr_q[1], 8'h01);
    chk("full_valid", instr_valid, 1);
    chk("full_head", instr, 16'h4D00);
    chk("full_no_req", imem_req, 0);
    instr_ready = 1'b1;
    cyc();
    chk("release_dec", acc_q[0], 16'h4D00);
    chk("release_req_addr", req_addr_q[req_addr_q.size()-1], 8'h02);
    chk("release_req_cycle", req_cyc_q[req_cyc_q.size()-1], cyc_n - 1);

    // Jump while waiting on address 05 with a 3-cycle memory.
    do_reset();
    instr_ready = 1'b1; lat_cfg = 3;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc();
      if (req_addr_q.size() > 0 && req_addr_q[req_addr_q.size()-1] == 8'h05 &&
          req_cyc_q[req_cyc_q.size()-1] == cyc_n - 1) found = 1;
    end
    chk("jump_setup_reached", found, 1);
    pc_jump = 1'b1; redirect_target = 8'h80;
    cyc();
    pc_jump = 1'b0;
    n0 = req_addr_q.size(); a0 = acc_q.size();
    for (int i = 0; i < 60 && (acc_q.size() <= a0); i++) cyc();
    chk("jump_next_addr", req_addr_q[n0], 8'h80);
    chk("jump_next_instr", acc_q[a0], 16'h4D80);

    // Branch near the top of the address space to cover PC wrap.
    lat_cfg = 1;
    pc_branch = 1'b1; redirect_target = 8'hFE;
    cyc();
    pc_branch = 1'b0;
    n0 = req_addr_q.size();
    for (int i = 0; i < 60 && (req_addr_q.size() < n0 + 4); i++) cyc();
    chk("wrap_addr_fe", req_addr_q[n0],   8'hFE);
    chk("wrap_addr_ff", req_addr_q[n0+1], 8'hFF);
    chk("wrap_addr_00", req_addr_q[n0+2], 8'h00);
    chk("wrap_addr_01", req_addr_q[n0+3], 8'h01);

    // Randomized traffic against the stream model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      instr_ready     = ($urandom_range(0, 3) != 0);
      lat_cfg         = $urandom_range(1, 3);
      pc_jump         = ($urandom_range(0, 29) == 0);
      pc_branch       = ($urandom_range(0, 29) == 0);
      redirect_target = 8'($urandom);
      cyc();
    end
    pc_jump = 1'b0; pc_branch = 1'b0;
    chk("random_progress", acc_q.size() > 200, 1);
`ifdef IFU_FETCH_STATS_EN
    chk("random_fetch_cnt", fetch_cnt, pushes_m[15:0]);
    chk("random_flush_cnt", flush_cnt, flushes_m[15:0]);

    // Four pushes, then a redirect that kills an in-flight fetch.
    do_reset();
    instr_ready = 1'b1; lat_cfg = 1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cyc();
      if (pushes_m == 4 && pending) found = 1;
    end
    chk("stats_setup_reached", found, 1);
    pc_jump = 1'b1; redirect_target = 8'h40;
    cyc();
    pc_jump = 1'b0;
    instr_ready = 1'b0;
    cyc();
    chk("stats_fetch_cnt", fetch_cnt, 16'd4);
    chk("stats_flush_cnt", flush_cnt, 16'd1);
`endif

    // Reset asserted mid-WAIT with an entry sitting in the queue.
    do_reset();
    instr_ready = 1'b0; lat_cfg = 3;
    repeat (5) cyc();
    chk("midwait_valid_before", instr_valid, 1);
    chk("midwait_pending_before", pending, 1);
    do_reset();
    cyc();
    chk("post_reset_req_addr", req_addr_q[0], 8'h00);
    chk("post_reset_req_cycle", req_cyc_q[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
